pico_uart_tx: RTL
=================

Name: pico_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a bus responder to the CPU, on the same ADDR/RE/WE/WDATA/RDATA bus as the memory and port block.
- CPU writes bytes into a small FIFO; a baud-rate FSM serialises them on TXD as 8N1 frames, LSB first.
- Top-level address decode drives SEL; the block uses ADDR[1:0] as the register offset.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DIV_RST, 8'd15, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RES  input  1  synchronous, active-low reset.
- SEL  input  1  block selected by the top-level address decode.
- ADDR  input  6  bus address; only [1:0] used.
- RE  input  1  read strobe.
- WE  input  1  write strobe.
- WDATA  input  8  write data.
- RDATA  output  8  read data; combinational; 8'h00 unless SEL&RE, so it can be OR-muxed with the memory.
- TXD  output  1  serial output, registered, idle high.
- IRQ  output  1  level: FIFO empty and FSM idle, or OVF set.

Behaviour:
- Reset (RES=0 at an edge): FIFO emptied, FSM=IDLE, TXD=1, BAUDDIV=DIV_RST, EN=0, OVF=0. Applies mid-frame: TXD=1 after that edge and the frame is abandoned. RDATA=0 and IRQ=1 out of reset.
- Register map, offsets on ADDR[1:0]:
  - 0 TXDATA: write pushes WDATA; reads return 0.
  - 1 STATUS (read-only): bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF, others 0.
  - 2 BAUDDIV: read/write, 8 bits.
  - 3 CTRL: bit0 EN (read/write); writing bit7=1 clears OVF; read bit7=0.
- A write takes effect at the edge where SEL&WE=1. RE and WE are never asserted together.
- Push when FULL: data is dropped and OVF is set. FULL is evaluated before any same-cycle pop, so a concurrent pop does not rescue the write.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: if EN=1 and FIFO not empty, pop into the shift register, reload the baud counter and go to START; TXD<=0 at the same edge.
  - START: hold for BAUDDIV+1 cycles, then go to DATA with TXD<=shift[0].
  - DATA: 8 bits LSB first, each held BAUDDIV+1 cycles; 3-bit counter; after bit 7, go to STOP with TXD<=1.
  - STOP: hold BAUDDIV+1 cycles, then go to IDLE.
- Frame timing:
  - Frame is 10*(BAUDDIV+1) cycles, plus one idle-high IDLE cycle between back-to-back frames.
  - Write to an empty FIFO with an idle FSM: TXD falls at the second rising edge counting the write-sampling edge.
- Baud counter counts down from BAUDDIV to 0; the bit ends when it reaches 0. A BAUDDIV change mid-frame takes effect at the next bit boundary reload. BAUDDIV=0 gives 1 cycle per bit.
- EN cleared mid-frame: the current frame completes and no further pops occur. FIFO contents are retained.
- FIFO pointers are log2(DEPTH) bits plus a wrap bit. FULL and EMPTY are derived from the pointers and wrap around modulo DEPTH.

Optional Feature:
- Macro: PICO_UART_TX_PARITY_EN.
- Defined: CTRL bit1 PEN (read/write, reset 0). When PEN=1, a PARITY state follows DATA and sends even parity (XOR of the 8 bits) for BAUDDIV+1 cycles, giving an 11-bit frame.
- Undefined: no PARITY state; CTRL bit1 reads 0 and writes are ignored.

Decomposition:
- Package pico_uart_pkg:
  - register offset constants (OFS_TXDATA=2'd0, OFS_STATUS=2'd1, OFS_BAUDDIV=2'd2, OFS_CTRL=2'd3);
  - STATUS bit index constants;
  - FSM state enum typedef.
- Sub-module pico_sync_fifo: parameterised width/depth; ports push, pop, din, dout, full, empty; synchronous active-low reset.

Test Plan:
- Reset with RES=0 for 2 cycles, then read STATUS -> 8'h04; TXD=1; IRQ=1; BAUDDIV reads 8'h0F.
- Write BAUDDIV=3, CTRL=1, then TXDATA=8'h55 -> TXD=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1; BUSY=1 throughout; IRQ=1 after the frame.
- With EN=0, write 5 bytes into DEPTH=4 -> STATUS=8'h0A (FULL, OVF). Write CTRL=8'h81 -> OVF cleared; 4 frames sent in order; the 5th byte is never sent.
- BAUDDIV=0, two bytes queued -> each frame is 10 cycles; exactly one idle-high cycle between frames.
- RES=0 during DATA bit 3 -> TXD=1 at the next edge; STATUS=8'h04; no further frames sent.
- With PICO_UART_TX_PARITY_EN defined, CTRL=8'h03, TXDATA=8'h07 -> 11-bit frame with parity bit=1; with CTRL=8'h01 -> 10-bit frame.

Source files
------------

// File: rtl/pico_uart_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and TX FSM states for pico_uart_tx.
package pico_uart_pkg;

    localparam logic [1:0] OFS_TXDATA  = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_BAUDDIV = 2'd2;
    localparam logic [1:0] OFS_CTRL    = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_PEN    = 1;
    localparam int CTRL_OVFCLR = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/pico_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pushes when full and pops when empty are ignored.
module pico_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pico_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Optional even-parity bit (CTRL bit1) when PICO_UART_TX_PARITY_EN is defined.
module pico_uart_tx
    import pico_uart_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] DIV_RST = 8'd15
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       SEL,
    input  logic [5:0] ADDR,
    input  logic       RE,
    input  logic       WE,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       TXD,
    output logic       IRQ
);

    tx_state_e  state_q, state_d;
    logic [7:0] baud_q;
    logic       en_q;
    logic       ovf_q;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       txd_q, txd_d;
    logic       pop;
    logic       pen_rd;

    logic       wr, wr_tx;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_dout;
    logic       last;
    logic       unused_addr;

    assign unused_addr = ^ADDR[5:2];
    assign wr    = SEL & WE;
    assign wr_tx = wr && (ADDR[1:0] == OFS_TXDATA);
    assign last  = (cnt_q == 8'd0);

    pico_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RES),
        .push  (wr_tx),
        .pop   (pop),
        .din   (WDATA),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef PICO_UART_TX_PARITY_EN
    logic pen_q;
    assign pen_rd = pen_q;

    always_ff @(posedge CLK) begin
        if (!RES)                                  pen_q <= 1'b0;
        else if (wr && ADDR[1:0] == OFS_CTRL)      pen_q <= WDATA[CTRL_PEN];
    end
`else
    assign pen_rd = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RES) begin
            baud_q <= DIV_RST;
            en_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr && ADDR[1:0] == OFS_BAUDDIV) baud_q <= WDATA;
            if (wr && ADDR[1:0] == OFS_CTRL) begin
                en_q <= WDATA[CTRL_EN];
                if (WDATA[CTRL_OVFCLR]) ovf_q <= 1'b0;
            end
            // FULL is the pre-pop value, so a same-edge pop never rescues the write
            if (wr_tx && fifo_full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = baud_q;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    bit_d   = 3'd0;
                    cnt_d   = baud_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (last) begin
                    cnt_d = baud_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`ifdef PICO_UART_TX_PARITY_EN
                        if (pen_q) begin
                            state_d = S_PARITY;
                            txd_d   = ^shift_q;
                        end
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PARITY: begin
                if (last) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    cnt_d   = baud_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STOP: begin
                if (last) state_d = S_IDLE;
                else      cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Zero when not read-selected so the bus can OR this with other responders
    always_comb begin
        RDATA = 8'h00;
        if (SEL && RE) begin
            unique case (ADDR[1:0])
                OFS_TXDATA:  RDATA = 8'h00;
                OFS_STATUS:  RDATA = {4'b0, ovf_q, fifo_empty, fifo_full, (state_q != S_IDLE)};
                OFS_BAUDDIV: RDATA = baud_q;
                OFS_CTRL:    RDATA = {6'b0, pen_rd, en_q};
                default:     RDATA = 8'h00;
            endcase
        end
    end

    assign TXD = txd_q;
    assign IRQ = (fifo_empty && state_q == S_IDLE) || ovf_q;

endmodule
